// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3-column shift register.
// A pixel accepted in cycle T produces its window in cycle T+2, for interior centres only.
module window_3x3_gen #(
  parameter int PIX_W      = 8,
  parameter int CORD_WIDTH = 11,
  parameter int ACTIVE_W   = 1280,
  parameter int ACTIVE_H   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      pixel_in,
  input  logic [CORD_WIDTH-1:0] pixel_x,
  input  logic [CORD_WIDTH-1:0] pixel_y,
  output logic                  out_valid,
  output logic [9*PIX_W-1:0]    window,
  output logic [CORD_WIDTH-1:0] out_x,
  output logic [CORD_WIDTH-1:0] out_y
);

  localparam int AW = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam logic [CORD_WIDTH-1:0] W_LIM = CORD_WIDTH'(ACTIVE_W);
  localparam logic [CORD_WIDTH-1:0] H_LIM = CORD_WIDTH'(ACTIVE_H);
  localparam logic [CORD_WIDTH-1:0] ONE   = CORD_WIDTH'(1);
  localparam logic [CORD_WIDTH-1:0] TWO   = CORD_WIDTH'(2);

  logic          accept;
  logic          origin;
  logic [AW-1:0] addr;

  logic [PIX_W-1:0] lb0_mem [ACTIVE_W];
  logic [PIX_W-1:0] lb1_mem [ACTIVE_W];
  logic [PIX_W-1:0] lb0_q;
  logic [PIX_W-1:0] lb1_q;

  logic                  synced;
  logic                  s1_valid;
  logic                  s1_ok;
  logic [PIX_W-1:0]      s1_pix;
  logic [CORD_WIDTH-1:0] s1_x;
  logic [CORD_WIDTH-1:0] s1_y;
  logic [AW-1:0]         s1_addr;

  logic [2:0][2:0][PIX_W-1:0] win;

  assign accept = in_valid && (pixel_x < W_LIM) && (pixel_y < H_LIM);
  assign origin = accept && (pixel_x == '0) && (pixel_y == '0);
  assign addr   = pixel_x[AW-1:0];

  // Synchronous-read line buffers. lb1 is written one cycle late from the registered lb0
  // read data, so each RAM sees one read and one write port and still maps onto BRAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q         <= lb0_mem[addr];
      lb1_q         <= lb1_mem[addr];
      lb0_mem[addr] <= pixel_in;
    end
    if (s1_valid) begin
      lb1_mem[s1_addr] <= lb0_q;
    end
  end

  // Stage 1 carries the accepted pixel alongside the RAM read; the interior/synced
  // decision is made here so the output stage only has to register it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced   <= 1'b0;
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_pix   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pix  <= pixel_in;
        s1_x    <= pixel_x - ONE;
        s1_y    <= pixel_y - ONE;
        s1_addr <= addr;
        s1_ok   <= (pixel_x >= TWO) && (pixel_y >= TWO) && (synced || origin);
      end
      if (origin) begin
        synced <= 1'b1;
      end
    end
  end

  // Column shift: column 2 is the newest (x), column 0 the oldest (x-2); row 0 is y-2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= s1_valid && s1_ok;
      if (s1_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_q;
        win[1][2] <= lb0_q;
        win[2][2] <= s1_pix;
        if (s1_ok) begin
          out_x <= s1_x;
          out_y <= s1_y;
        end
      end
    end
  end

  assign window = win;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on an 8x6 frame: a scoreboard queue holds the expected
// window and due cycle of every interior accept; a negedge monitor pops and compares.
module tb_window_3x3_gen;

  localparam int PIX_W = 8;
  localparam int CW    = 11;
  localparam int AW_T  = 8;
  localparam int AH_T  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [PIX_W-1:0] pixel_in;
  logic [CW-1:0]   pixel_x;
  logic [CW-1:0]   pixel_y;
  logic            out_valid;
  logic [71:0]     window;
  logic [CW-1:0]   out_x;
  logic [CW-1:0]   out_y;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [71:0]   win;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_count = 0;
  bit   model_synced = 1'b0;

  window_3x3_gen #(
    .PIX_W(PIX_W), .CORD_WIDTH(CW), .ACTIVE_W(AW_T), .ACTIVE_H(AH_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pixel_in(pixel_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .out_valid(out_valid),
    .window(window), .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(int x, int y);
    return 8'((x + 16 * y) % 256);
  endfunction

  function automatic logic [71:0] exp_window(int x, int y);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = pix(x - 2 + c, y - 2 + r);
    return w;
  endfunction

  task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every out_valid must match the oldest scoreboard entry, including its due cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      out_count++;
      if (sb.size() == 0) begin
        check_output("unexpected_out_valid", 72'(1), 72'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("out_x", 72'(out_x), 72'(e.x));
        check_output("out_y", 72'(out_y), 72'(e.y));
        check_output("window", window, e.win);
        check_output("latency_cycle", 72'(cyc), 72'(e.due));
      end
    end
  end

  task automatic apply_stimulus(input int x, input int y);
    exp_t e;
    in_valid = 1'b1;
    pixel_x  = CW'(x);
    pixel_y  = CW'(y);
    pixel_in = pix(x, y);
    if (x < AW_T && y < AH_T) begin
      if (x == 0 && y == 0) model_synced = 1'b1;
      if (x >= 2 && y >= 2 && model_synced) begin
        e.x   = CW'(x - 1);
        e.y   = CW'(y - 1);
        e.win = exp_window(x, y);
        e.due = cyc + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_idle(input int n);
    in_valid = 1'b0;
    pixel_x  = CW'($urandom_range(0, 2047));
    pixel_y  = CW'($urandom_range(0, 2047));
    pixel_in = 8'($urandom_range(0, 255));
    repeat (n) @(negedge clk);
  endtask

  // mode 0: contiguous, 1: one idle after each pixel, 2: random stalls of 0..3 cycles
  task automatic send_row(input int y, input int x0, input int x1, input int mode);
    for (int x = x0; x <= x1; x++) begin
      apply_stimulus(x, y);
      if (mode == 1) apply_idle(1);
      else if (mode == 2) apply_idle($urandom_range(0, 3));
    end
  endtask

  task automatic send_frame(input int mode, input bit blank, input int y0);
    for (int y = y0; y < AH_T; y++) begin
      send_row(y, 0, AW_T - 1, mode);
      if (blank)
        for (int bx = AW_T; bx < AW_T + 4; bx++) apply_stimulus(bx, y);
    end
  endtask

  task automatic check_count(input string tag, input int c0, input int expected);
    apply_idle(4);
    check_output(tag, 72'(out_count - c0), 72'(expected));
  endtask

  task automatic model_reset();
    sb.delete();
    model_synced = 1'b0;
  endtask

  initial begin
    int c0;
    in_valid = 1'b0;
    pixel_in = '0;
    pixel_x  = '0;
    pixel_y  = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("reset_out_valid", 72'(out_valid), 72'(0));
    check_output("reset_window", window, 72'(0));
    check_output("reset_out_x", 72'(out_x), 72'(0));
    check_output("reset_out_y", 72'(out_y), 72'(0));
    rst_n = 1'b1;
    apply_idle(2);

    $display("[TB] frame 1 with first-window check");
    c0 = out_count;
    send_row(0, 0, 7, 0);
    send_row(1, 0, 7, 0);
    send_row(2, 0, 2, 0);
    apply_idle(1);
    check_output("first_out_valid", 72'(out_valid), 72'(1));
    check_output("first_out_x", 72'(out_x), 72'(1));
    check_output("first_out_y", 72'(out_y), 72'(1));
    check_output("first_window", window, 72'h22_21_20_12_11_10_02_01_00);
    send_row(2, 3, 7, 0);
    for (int y = 3; y < AH_T; y++) send_row(y, 0, 7, 0);
    check_count("frame1_count", c0, 24);

    $display("[TB] frame 2 contiguous");
    c0 = out_count;
    send_frame(0, 1'b0, 0);
    check_count("frame2_count", c0, 24);

    $display("[TB] toggled and stalled in_valid");
    c0 = out_count;
    send_frame(1, 1'b0, 0);
    check_count("toggle_count", c0, 24);
    c0 = out_count;
    send_frame(2, 1'b0, 0);
    check_count("stall_count", c0, 24);

    $display("[TB] blanking coordinates with in_valid high");
    c0 = out_count;
    send_frame(0, 1'b1, 0);
    check_count("blank_count", c0, 24);

    $display("[TB] reset released mid-frame");
    rst_n = 1'b0;
    model_reset();
    apply_idle(2);
    rst_n = 1'b1;
    c0 = out_count;
    send_frame(0, 1'b0, 3);
    check_count("midframe_count", c0, 0);
    c0 = out_count;
    send_frame(0, 1'b0, 0);
    check_count("after_midframe_count", c0, 24);

    $display("[TB] asynchronous reset mid-line at (4,3)");
    send_row(0, 0, 7, 0);
    send_row(1, 0, 7, 0);
    send_row(2, 0, 7, 0);
    send_row(3, 0, 3, 0);
    check_output("pre_reset_out_valid", 72'(out_valid), 72'(1));
    in_valid = 1'b1;
    pixel_x  = CW'(4);
    pixel_y  = CW'(3);
    pixel_in = pix(4, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_out_valid", 72'(out_valid), 72'(0));
    check_output("async_window", window, 72'(0));
    check_output("async_out_x", 72'(out_x), 72'(0));
    check_output("async_out_y", 72'(out_y), 72'(0));
    apply_idle(1);
    rst_n = 1'b1;
    c0 = out_count;
    send_row(3, 5, 7, 0);
    send_frame(0, 1'b0, 4);
    check_count("after_async_count", c0, 0);
    c0 = out_count;
    send_frame(2, 1'b0, 0);
    check_count("recover_count", c0, 24);

    apply_idle(4);
    check_output("scoreboard_empty", 72'(sb.size()), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
